// File: rtl/seq_div_16_if.sv
// Start/done handshake bundle for the iterative unsigned divider.
// The master issues operands; the slave returns quotient, remainder and flags.
interface seq_div_16_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_div_16.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Divide-by-zero completes in the accepting cycle with an all-ones quotient.
module seq_div_16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_div_16_if.slave  bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [0:0] {StIdle, StCalc} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    // Partial remainder is always < divisor between steps, so WIDTH bits hold it;
    // the shifted value and the trial subtract are WIDTH+1 bits wide.
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             q_bit;

    assign r_shift = {rem_q, shreg_q[WIDTH-1]};
    assign trial   = r_shift - {1'b0, dvsr_q};
    assign q_bit   = ~trial[WIDTH];

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quot_d = '1;
                        remo_d = bus.dividend;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        shreg_d = bus.dividend;
                        dvsr_d  = bus.divisor;
                        rem_d   = '0;
                        cnt_d   = CntW'(WIDTH);
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                shreg_d = {shreg_q[WIDTH-2:0], q_bit};
                rem_d   = q_bit ? trial[WIDTH-1:0] : r_shift[WIDTH-1:0];
                cnt_d   = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    quot_d  = shreg_d;
                    remo_d  = rem_d;
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shreg_q <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = (state_q == StCalc);
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = remo_q;
    assign bus.div_by_zero = dbz_q;
endmodule
